sha256_msg_driver: RTL and testbench



---
 rtl/sha256_pkg.sv | 35 +++
 rtl/sha256_pad_block.sv | 47 ++++
 rtl/sha256_msg_driver.sv | 156 +++++++++++++++
 tb/tb_sha256_msg_driver.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions for the message driver and its padding helper.
//   blk_t      : one 512-bit block, element [i] = message word i
//   hash_t     : one 256-bit chaining value, element [i] = H_i
//   H_INIT     : FIPS-180 initial hash value
//   PAD_MARKER : the single '1' bit that follows the message
//   state_e    : driver FSM states
//   pad_mode_e : padding block flavour
package sha256_pkg;

    typedef logic [15:0][31:0] blk_t;
    typedef logic [7:0][31:0]  hash_t;

    localparam logic [31:0] PAD_MARKER = 32'h8000_0000;

    // Packed literal lists the highest element first, so H7 leads and H0 ends.
    localparam hash_t H_INIT = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PAD,
        ISSUE,
        WAIT,
        OUTPUT
    } state_e;

    typedef enum logic {
        PAD_TAIL,   // pad the partially filled block in place
        PAD_EXTRA   // build the trailing length-only block
    } pad_mode_e;

endpackage

// File: rtl/sha256_pad_block.sv
// Combinational SHA-256 padding of one block.
//   blk_in   : block words as loaded so far
//   idx      : number of valid message words in blk_in (0..16)
//   word_cnt : total message length in 32-bit words
//   mode     : PAD_TAIL pads blk_in in place, PAD_EXTRA builds the trailer block
//   marker   : PAD_EXTRA only, put the 0x80000000 marker in word 0
//   blk_out  : padded block
module sha256_pad_block
    import sha256_pkg::*;
#(
    parameter int LEN_W = 32
) (
    input  logic [15:0][31:0] blk_in,
    input  logic [4:0]        idx,
    input  logic [LEN_W-1:0]  word_cnt,
    input  pad_mode_e         mode,
    input  logic              marker,
    output logic [15:0][31:0] blk_out
);

    logic [63:0] bit_len;

    assign bit_len = 64'(word_cnt) << 5;

    always_comb begin
        blk_out = '0;
        if (mode == PAD_EXTRA) begin
            blk_out[0]  = marker ? PAD_MARKER : 32'h0;
            blk_out[14] = bit_len[63:32];
            blk_out[15] = bit_len[31:0];
        end else begin
            // idx == 16 leaves the block untouched; marker spills into PAD_EXTRA.
            for (int i = 0; i < 16; i++) begin
                if (5'(i) < idx)
                    blk_out[i] = blk_in[i];
                else if (5'(i) == idx)
                    blk_out[i] = PAD_MARKER;
            end
            // Length fits only when words 14..15 are still free after the marker.
            if (idx <= 5'd13) begin
                blk_out[14] = bit_len[63:32];
                blk_out[15] = bit_len[31:0];
            end
        end
    end

endmodule

// File: rtl/sha256_msg_driver.sv
// Streams a word-oriented message into a SHA-256 compression core: buffers
// 16-word blocks, applies FIPS-180 padding, chains the hash across blocks and
// presents the final digest.
//   clk, reset            : clock, synchronous active-high reset
//   in_valid/ready/data/last : message word stream (big-endian words)
//   core_start            : one-cycle start pulse to the core
//   core_message/core_hash: block and chaining value, stable while the core runs
//   core_done/core_sha    : core result pulse and value
//   out_valid/out_ready   : digest handshake
//   digest                : final hash, word 0 = H0
module sha256_msg_driver
    import sha256_pkg::*;
#(
    parameter int LEN_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    input  logic              in_last,
    output logic              core_start,
    output logic [15:0][31:0] core_message,
    output logic [7:0][31:0]  core_hash,
    input  logic              core_done,
    input  logic [7:0][31:0]  core_sha,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0][31:0]  digest
);

    state_e            state, nxt;
    blk_t              blk_q;
    hash_t             hash_q;
    logic [4:0]        idx_q;
    logic [LEN_W-1:0]  word_cnt_q;
    logic              final_q;
    logic              len_pend_q;
    logic              mark_pend_q;
    blk_t              pad_blk;
    pad_mode_e         pad_mode;

    // One padder serves both the in-place pad (PAD) and the trailer block (WAIT).
    assign pad_mode = (state == PAD) ? PAD_TAIL : PAD_EXTRA;

    sha256_pad_block #(.LEN_W(LEN_W)) u_pad (
        .blk_in   (blk_q),
        .idx      (idx_q),
        .word_cnt (word_cnt_q),
        .mode     (pad_mode),
        .marker   (mark_pend_q),
        .blk_out  (pad_blk)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt        = state;
        in_ready   = 1'b0;
        core_start = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) nxt = in_last ? PAD : LOAD;
            end
            LOAD: begin
                in_ready = (idx_q < 5'd16);
                if (in_ready && in_valid) begin
                    if (in_last)             nxt = PAD;
                    else if (idx_q == 5'd15) nxt = ISSUE;
                end
            end
            PAD:   nxt = ISSUE;
            ISSUE: begin
                core_start = 1'b1;
                nxt        = WAIT;
            end
            WAIT: begin
                if (core_done) begin
                    if (final_q)         nxt = OUTPUT;
                    else if (len_pend_q) nxt = ISSUE;
                    else                 nxt = LOAD;
                end
            end
            OUTPUT: begin
                out_valid = 1'b1;
                if (out_ready) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blk_q       <= '0;
            hash_q      <= '0;
            idx_q       <= '0;
            word_cnt_q  <= '0;
            final_q     <= 1'b0;
            len_pend_q  <= 1'b0;
            mark_pend_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        hash_q      <= H_INIT;
                        blk_q[0]    <= in_data;
                        idx_q       <= 5'd1;
                        word_cnt_q  <= LEN_W'(1);
                        final_q     <= 1'b0;
                        len_pend_q  <= 1'b0;
                        mark_pend_q <= 1'b0;
                    end
                end
                LOAD: begin
                    if (in_valid && idx_q < 5'd16) begin
                        blk_q[idx_q[3:0]] <= in_data;
                        idx_q             <= idx_q + 5'd1;
                        word_cnt_q        <= word_cnt_q + LEN_W'(1);
                    end
                end
                PAD: begin
                    blk_q       <= pad_blk;
                    final_q     <= (idx_q <= 5'd13);
                    len_pend_q  <= (idx_q >  5'd13);
                    mark_pend_q <= (idx_q == 5'd16);
                end
                WAIT: begin
                    if (core_done) begin
                        hash_q <= core_sha;
                        if (!final_q) begin
                            if (len_pend_q) begin
                                blk_q       <= pad_blk;
                                final_q     <= 1'b1;
                                len_pend_q  <= 1'b0;
                                mark_pend_q <= 1'b0;
                            end else begin
                                idx_q <= 5'd0;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign core_message = blk_q;
    assign core_hash    = hash_q;
    assign digest       = hash_q;

endmodule

// File: tb/tb_sha256_msg_driver.sv
module tb_sha256_msg_driver;

    typedef logic [7:0][31:0]  hv_t;
    typedef logic [15:0][31:0] mb_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid, in_ready, in_last;
    logic [31:0]       in_data;
    logic              core_start, core_done;
    logic [15:0][31:0] core_message;
    logic [7:0][31:0]  core_hash, core_sha, digest;
    logic              out_valid, out_ready;

    always #5 clk = ~clk;

    sha256_msg_driver #(.LEN_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .core_start   (core_start),
        .core_message (core_message),
        .core_hash    (core_hash),
        .core_done    (core_done),
        .core_sha     (core_sha),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .digest       (digest)
    );

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam hv_t IV = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };

    // SHA-256("abcd"), H7 first so that element 0 is H0.
    localparam hv_t ABCD_DIGEST = {
        32'h6f031589, 32'ha3e16193, 32'h23b9217d, 32'h209c8978,
        32'hf289579d, 32'h13b845fc, 32'hd4e6338d, 32'h88d4266f
    };

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic hv_t compress(input hv_t h, input mb_t m);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
        hv_t r;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) w[t] = m[t];
            else w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                      + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        end
        a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4]; f = h[5]; g = h[6]; hh = h[7];
        for (int t = 0; t < 64; t++) begin
            t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        r[0] = h[0] + a; r[1] = h[1] + b; r[2] = h[2] + c; r[3] = h[3] + d;
        r[4] = h[4] + e; r[5] = h[5] + f; r[6] = h[6] + g; r[7] = h[7] + hh;
        return r;
    endfunction

    function automatic hv_t rand256();
        hv_t r;
        for (int i = 0; i < 8; i++) r[i] = $urandom;
        return r;
    endfunction

    logic [31:0] msg_q [$];
    mb_t         exp_blk [$];
    hv_t         exp_hash [$];
    bit          skip_stab = 1'b0;
    bit          spur_en   = 1'b0;
    bit          core_busy = 1'b0;

    // Reference: standard FIPS-180 padding of the whole message, then chain.
    task automatic ref_msg(output hv_t dg);
        logic [31:0] wq [$];
        logic [63:0] bits;
        mb_t blk;
        hv_t h;
        wq   = msg_q;
        bits = 64'(msg_q.size()) * 64'd32;
        wq.push_back(32'h8000_0000);
        while (wq.size() % 16 != 14) wq.push_back(32'h0);
        wq.push_back(bits[63:32]);
        wq.push_back(bits[31:0]);
        h = IV;
        for (int b = 0; b < wq.size() / 16; b++) begin
            for (int i = 0; i < 16; i++) blk[i] = wq[b*16 + i];
            exp_blk.push_back(blk);
            exp_hash.push_back(h);
            h = compress(h, blk);
        end
        dg = h;
    endtask

    // Compression core stand-in with random latency and optional stray done pulses.
    initial begin : core_model
        mb_t lm;
        hv_t lh;
        int  lat;
        bit  prev_start;
        lat        = 0;
        prev_start = 1'b0;
        core_done  = 1'b0;
        core_sha   = '0;
        forever begin
            @(posedge clk); #1;
            core_done = 1'b0;
            core_sha  = rand256();
            if (prev_start) check("start_one_cycle", core_start, 0);
            if (core_busy) begin
                if (lat == 0) begin
                    core_done = 1'b1;
                    core_sha  = compress(lh, lm);
                    core_busy = 1'b0;
                    if (!skip_stab) begin
                        check("msg_stable", core_message, lm);
                        check("hash_stable", core_hash, lh);
                    end
                end else lat--;
            end else if (core_start) begin
                lm        = core_message;
                lh        = core_hash;
                lat       = $urandom_range(0, 4);
                core_busy = 1'b1;
                check("blk_expected", exp_blk.size() != 0, 1);
                if (exp_blk.size() != 0) begin
                    check("core_message", core_message, exp_blk.pop_front());
                    check("core_hash", core_hash, exp_hash.pop_front());
                end
            end else if (spur_en && $urandom_range(0, 7) == 0) begin
                core_done = 1'b1;
            end
            prev_start = core_start;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic drive_words();
        int cnt;
        for (int i = 0; i < msg_q.size(); i++) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                in_last  = 1'($urandom_range(0, 1));
                step();
            end
            in_valid = 1'b1;
            in_data  = msg_q[i];
            in_last  = (i == msg_q.size() - 1);
            cnt = 0;
            while (!in_ready && cnt < 200) begin step(); cnt++; end
            if (!in_ready) begin
                check("in_ready_timeout", in_ready, 1);
                break;
            end
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_msg(input int hold, input bit use_known, input hv_t known);
        hv_t dg;
        int  cnt;
        ref_msg(dg);
        drive_words();
        cnt = 0;
        while (!out_valid && cnt < 2000) begin step(); cnt++; end
        check("out_valid", out_valid, 1);
        check("digest", digest, dg);
        if (use_known) check("digest_known", digest, known);
        check("blocks_left", exp_blk.size(), 0);
        repeat (hold) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            step();
            check("hold_valid", out_valid, 1);
            check("hold_digest", digest, dg);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("post_valid", out_valid, 0);
        check("post_in_ready", in_ready, 1);
    endtask

    task automatic fill_msg(input int n);
        msg_q.delete();
        for (int i = 0; i < n; i++) msg_q.push_back($urandom);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin : main
        int  lens [10] = '{13, 14, 15, 16, 17, 29, 30, 31, 32, 33};
        hv_t dg;
        int  cnt;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) step();
        reset = 1'b0;

        check("rst_in_ready", in_ready, 1);
        check("rst_core_start", core_start, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_digest", digest, 0);
        check("rst_core_message", core_message, 0);
        check("rst_core_hash", core_hash, 0);

        spur_en = 1'b1;

        msg_q.delete();
        msg_q.push_back(32'h6162_6364);
        run_msg(0, 1'b1, ABCD_DIGEST);

        foreach (lens[i]) begin
            fill_msg(lens[i]);
            run_msg((lens[i] == 13) ? 10 : 0, 1'b0, '0);
        end
        repeat (4) begin
            fill_msg($urandom_range(1, 48));
            run_msg($urandom_range(0, 3), 1'b0, '0);
        end

        // Reset while the core is busy; its late done must be ignored.
        fill_msg(1);
        ref_msg(dg);
        drive_words();
        cnt = 0;
        while (!core_start && cnt < 50) begin step(); cnt++; end
        check("rst_wait_start", core_start, 1);
        step();
        skip_stab = 1'b1;
        reset     = 1'b1;
        step();
        reset = 1'b0;
        cnt = 0;
        while (core_busy && cnt < 20) begin step(); cnt++; end
        repeat (3) step();
        check("rst_wait_out_valid", out_valid, 0);
        check("rst_wait_in_ready", in_ready, 1);
        check("rst_wait_core_hash", core_hash, 0);
        check("rst_wait_digest", digest, 0);
        skip_stab = 1'b0;
        exp_blk.delete();
        exp_hash.delete();

        fill_msg(20);
        run_msg(2, 1'b0, '0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
